// File: rtl/spc_ctrl_pkg.sv
// spc_ctrl_pkg: shared state encoding, default parameters and PC type for the spc checkpoint sequencer.
package spc_ctrl_pkg;
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    HALT    = 3'd1,
    RESTORE = 3'd2,
    RESUME  = 3'd3,
    FAIL    = 3'd4
  } state_e;
  localparam int PC_WIDTH_DEF      = 32;
  localparam int CKPT_INTERVAL_DEF = 16;
  localparam int MAX_RETRY_DEF     = 3;
  localparam int HALT_TIMEOUT_DEF  = 64;
  typedef logic [PC_WIDTH_DEF-1:0] pc_t;
endpackage

// File: rtl/spc_ckpt_timer.sv
// spc_ckpt_timer: counts commits, captures the checkpoint PC and gates the spc save strobe.
module spc_ckpt_timer
  import spc_ctrl_pkg::*;
#(
  parameter int PC_WIDTH      = PC_WIDTH_DEF,
  parameter int CKPT_INTERVAL = CKPT_INTERVAL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                error_i,
  input  logic                clr,
  input  logic                commit_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                save_o,
  output logic [PC_WIDTH-1:0] pc_o
);
  localparam int CW = $clog2(CKPT_INTERVAL + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic pend_q, pend_d, take, hit;
  // An erroring cycle neither counts its commit nor lets a pending save through.
  always_comb begin
    take   = en & ~error_i & commit_i;
    hit    = take & (cnt_q == CW'(CKPT_INTERVAL - 1));
    save_o = pend_q & en & ~error_i;
    cnt_d  = (clr | hit) ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    pend_d = hit | (pend_q & ~save_o & ~(en & error_i));
    pc_d   = hit ? pc_i : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      pc_q   <= pc_d;
    end
  end
  assign pc_o = pc_q;
endmodule

// File: rtl/spc_ctrl.sv
// spc_ctrl: checkpoint/rollback sequencer for the saved-PC register of the lockstep core pair.
// Optional error log ports (err_pc_o, err_count_o) are built when SPC_CTRL_ERR_LOG_EN is defined.
module spc_ctrl
  import spc_ctrl_pkg::*;
#(
  parameter int PC_WIDTH      = PC_WIDTH_DEF,
  parameter int CKPT_INTERVAL = CKPT_INTERVAL_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF,
  parameter int HALT_TIMEOUT  = HALT_TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             commit_i,
  input  logic [PC_WIDTH-1:0]              pc_i,
  input  logic                             error_i,
  input  logic                             halt_ack_i,
  input  logic [PC_WIDTH-1:0]              spc_q_i,
  output logic                             spc_save_o,
  output logic [PC_WIDTH-1:0]              spc_pc_o,
  output logic                             halt_req_o,
  output logic                             restore_o,
  output logic [PC_WIDTH-1:0]              restore_pc_o,
  output logic                             fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o,
`ifdef SPC_CTRL_ERR_LOG_EN
  output logic [PC_WIDTH-1:0]              err_pc_o,
  output logic [15:0]                      err_count_o,
`endif
  output logic [2:0]                       state_o
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PC_WIDTH-1:0] rpc_q, rpc_d;
  logic clr;
  spc_ckpt_timer #(.PC_WIDTH(PC_WIDTH), .CKPT_INTERVAL(CKPT_INTERVAL)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == RUN),
    .error_i  (error_i),
    .clr      (clr),
    .commit_i (commit_i),
    .pc_i     (pc_i),
    .save_o   (spc_save_o),
    .pc_o     (spc_pc_o)
  );
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    tmo_d      = '0;
    rpc_d      = rpc_q;
    clr        = 1'b0;
    halt_req_o = state_q inside {HALT, RESTORE, FAIL};
    restore_o  = state_q == RESTORE;
    fail_o     = state_q == FAIL;
    case (state_q)
      RUN:
        if (error_i) state_d = (retry_q == RW'(MAX_RETRY)) ? FAIL : HALT;
        else if (spc_save_o) retry_d = '0;
      HALT: begin
        tmo_d = tmo_q + 1'b1;
        if (halt_ack_i) begin
          state_d = RESTORE;
          rpc_d   = spc_q_i;
        end else if (tmo_q == TW'(HALT_TIMEOUT - 1)) state_d = FAIL;
      end
      RESTORE: begin
        retry_d = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;
        state_d = RESUME;
      end
      RESUME:
        if (!halt_ack_i) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      default: state_d = FAIL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      retry_q <= '0;
      tmo_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      rpc_q   <= rpc_d;
    end
  end
  assign restore_pc_o = rpc_q;
  assign retry_cnt_o  = retry_q;
  assign state_o      = state_q;
`ifdef SPC_CTRL_ERR_LOG_EN
  logic [PC_WIDTH-1:0] last_pc_q, last_pc_d, err_pc_q, err_pc_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic acc;
  always_comb begin
    acc       = (state_q == RUN) & error_i;
    last_pc_d = ((state_q == RUN) & commit_i & ~error_i) ? pc_i : last_pc_q;
    err_pc_d  = acc ? last_pc_q : err_pc_q;
    err_cnt_d = (acc & ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q <= '0;
      err_pc_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      err_pc_q  <= err_pc_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign err_pc_o    = err_pc_q;
  assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_spc_ctrl.sv
// tb_spc_ctrl: directed and randomized checks of spc_ctrl against a behavioural model of the sequencer.
module tb_spc_ctrl;
  localparam int CKI = 4, MAXR = 2, HT = 8;
  typedef struct {bit c; logic [31:0] p; bit e; bit a;} stim_t;
  logic clk = 1'b0, rst = 1'b0, commit_i = 1'b0, error_i = 1'b0, halt_ack_i = 1'b0;
  logic [31:0] pc_i = '0, spc_q_i = '0;
  logic spc_save_o, halt_req_o, restore_o, fail_o;
  logic [31:0] spc_pc_o, restore_pc_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;
`ifdef SPC_CTRL_ERR_LOG_EN
  logic [31:0] err_pc_o;
  logic [15:0] err_count_o;
`endif
  always #5 clk = ~clk;
  spc_ctrl #(.PC_WIDTH(32), .CKPT_INTERVAL(CKI), .MAX_RETRY(MAXR), .HALT_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst), .commit_i(commit_i), .pc_i(pc_i), .error_i(error_i),
    .halt_ack_i(halt_ack_i), .spc_q_i(spc_q_i), .spc_save_o(spc_save_o), .spc_pc_o(spc_pc_o),
    .halt_req_o(halt_req_o), .restore_o(restore_o), .restore_pc_o(restore_pc_o), .fail_o(fail_o),
    .retry_cnt_o(retry_cnt_o),
`ifdef SPC_CTRL_ERR_LOG_EN
    .err_pc_o(err_pc_o), .err_count_o(err_count_o),
`endif
    .state_o(state_o)
  );
  int nvec = 0, nerr = 0;
  // behavioural model: phase 0 run, 1 halt, 2 restore, 3 resume, 4 fail
  int m_state, m_cnt, m_retry, m_tmo;
  bit m_pend;
  logic [31:0] m_pc, m_rpc, m_spc = 32'h20;
  // obs layout: [72] save, [71:40] spc_pc, [39] halt, [38] restore, [37:6] restore_pc, [5] fail, [4:3] retry, [2:0] state
  logic [72:0] obs, expv;
  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_retry = 0; m_tmo = 0; m_pend = 0; m_pc = '0; m_rpc = '0;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1; commit_i = 1'b0; error_i = 1'b0; halt_ack_i = 1'b0; pc_i = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask
  task automatic step(input bit c, input logic [31:0] p, input bit e, input bit a);
    bit s;
    commit_i = c; pc_i = p; error_i = e; halt_ack_i = a; spc_q_i = m_spc;
    #2;
    s = m_pend && m_state == 0 && !e;
    obs = {spc_save_o, spc_pc_o, halt_req_o, restore_o, restore_pc_o, fail_o, retry_cnt_o, state_o};
    expv = {s, m_pc, (m_state == 1 || m_state == 2 || m_state == 4), m_state == 2, m_rpc,
            m_state == 4, 2'(m_retry), 3'(m_state)};
    @(posedge clk);
    case (m_state)
      0: if (e) begin
           m_pend = 0; m_tmo = 0;
           m_state = (m_retry == MAXR) ? 4 : 1;
         end else begin
           if (s) begin m_spc = m_pc; m_pend = 0; m_retry = 0; end
           if (c) begin
             m_cnt++;
             if (m_cnt == CKI) begin m_cnt = 0; m_pc = p; m_pend = 1; end
           end
         end
      1: if (a) begin m_rpc = m_spc; m_state = 2; end
         else begin m_tmo++; if (m_tmo == HT) m_state = 4; end
      2: begin if (m_retry < MAXR) m_retry++; m_state = 3; end
      3: if (!a) begin m_state = 0; m_cnt = 0; end
      default: ;
    endcase
    #1;
  endtask
  task automatic test_reset();
    do_reset(2);
    step(0, 32'h0, 0, 0);
    nvec++;
    if (obs !== '0) begin nerr++; $display("FAIL reset_state got=%h exp=0", obs); end
  endtask
  task automatic test_checkpoint();
    int saves = 0;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      step(i < 4, 32'h100 + 32'(4 * i), 0, 0);
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL ckpt[%0d] got=%h exp=%h", i, obs, expv); end
      saves += int'(obs[72]);
      if (i == 4) begin
        nvec++;
        if (obs[72] !== 1'b1 || obs[71:40] !== 32'h10C) begin
          nerr++; $display("FAIL ckpt_pulse save=%b pc=%h exp save=1 pc=10c", obs[72], obs[71:40]);
        end
      end
    end
    nvec++;
    if (saves != 1) begin nerr++; $display("FAIL ckpt_count got=%0d exp=1", saves); end
  endtask
  task automatic test_error_rollback();
    stim_t q[$];
    do_reset(1);
    m_spc = 32'h20;
    q = '{'{1, 32'h100, 0, 0}, '{1, 32'h104, 0, 0}, '{1, 32'h108, 0, 0}, '{1, 32'h10C, 1, 0},
          '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 1},
          '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    foreach (q[i]) begin
      step(q[i].c, q[i].p, q[i].e, q[i].a);
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL rollback[%0d] got=%h exp=%h", i, obs, expv); end
      if (i == 4) begin
        nvec++;
        if (obs[72] !== 1'b0 || obs[2:0] !== 3'd1) begin
          nerr++; $display("FAIL err_no_save save=%b state=%0d exp save=0 state=1", obs[72], obs[2:0]);
        end
      end
      if (i == 7) begin
        nvec++;
        if (obs[38] !== 1'b1 || obs[37:6] !== 32'h20) begin
          nerr++; $display("FAIL restore_pulse restore=%b pc=%h exp restore=1 pc=20", obs[38], obs[37:6]);
        end
      end
      if (i == 10) begin
        nvec++;
        if (obs[4:3] !== 2'd1 || obs[2:0] !== 3'd0) begin
          nerr++; $display("FAIL rollback_done retry=%0d state=%0d exp retry=1 state=0", obs[4:3], obs[2:0]);
        end
      end
    end
  endtask
  task automatic test_max_retry();
    do_reset(1);
    m_spc = 32'h40;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) step(0, 0, i % 4 == 0, i % 4 == 1 || i % 4 == 2);
      else step(1'($urandom_range(0, 1)), $urandom, i == 8 || i % 2 == 1, 1'($urandom_range(0, 1)));
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL maxretry[%0d] got=%h exp=%h", i, obs, expv); end
      if (i == 7) begin
        nvec++;
        if (obs[4:3] !== 2'd2) begin nerr++; $display("FAIL maxretry_cnt got=%0d exp=2", obs[4:3]); end
      end
      if (i >= 9) begin
        nvec++;
        if (obs[5] !== 1'b1 || obs[2:0] !== 3'd4 || obs[39] !== 1'b1) begin
          nerr++; $display("FAIL sticky_fail[%0d] fail=%b state=%0d exp fail=1 state=4", i, obs[5], obs[2:0]);
        end
      end
    end
  endtask
  task automatic test_timeout();
    int halts = 0;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, i == 0, 0);
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, expv); end
      halts += int'(obs[39] && obs[2:0] == 3'd1);
    end
    nvec++;
    if (halts != HT || obs[5] !== 1'b1) begin
      nerr++; $display("FAIL timeout_len halts=%0d fail=%b exp halts=%0d fail=1", halts, obs[5], HT);
    end
  endtask
  task automatic test_retry_clear();
    do_reset(1);
    m_spc = 32'h20;
    for (int i = 0; i < 13; i++) begin
      if (i < 4) step(0, 0, i == 0, i == 1 || i == 2);
      else if (i < 8) step(1, 32'h200 + 32'(4 * (i - 4)), 0, 0);
      else step(0, 0, i == 10, i == 11 || i == 12);
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL retryclr[%0d] got=%h exp=%h", i, obs, expv); end
      if (i == 9) begin
        nvec++;
        if (obs[4:3] !== 2'd0) begin nerr++; $display("FAIL retry_cleared got=%0d exp=0", obs[4:3]); end
      end
      if (i == 12) begin
        nvec++;
        if (obs[38] !== 1'b1 || obs[37:6] !== 32'h20C) begin
          nerr++; $display("FAIL new_ckpt_restore restore=%b pc=%h exp restore=1 pc=20c", obs[38], obs[37:6]);
        end
      end
    end
  endtask
  task automatic test_reset_in_restore();
    do_reset(1);
    step(1, 32'h300, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    nvec++;
    if (obs[2:0] !== 3'd2) begin nerr++; $display("FAIL reach_restore state=%0d exp=2", obs[2:0]); end
    do_reset(1);
    step(0, 0, 0, 0);
    nvec++;
    if (obs !== '0) begin nerr++; $display("FAIL reset_in_restore got=%h exp=0", obs); end
`ifdef SPC_CTRL_ERR_LOG_EN
    nvec++;
    if (err_count_o !== 16'd0) begin nerr++; $display("FAIL err_count_reset got=%0d exp=0", err_count_o); end
`endif
  endtask
  task automatic test_random();
    m_spc = $urandom;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 40);
      nvec++;
      if (obs !== expv) begin nerr++; $display("FAIL random[%0d] got=%h exp=%h", i, obs, expv); end
    end
  endtask
  initial begin
    test_reset();
    test_checkpoint();
    test_error_rollback();
    test_max_retry();
    test_timeout();
    test_retry_clear();
    test_reset_in_restore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/spc_ctrl.md
Name: spc_ctrl

Overview:
Checkpoint/rollback sequencer for the saved-PC register (spc) in the fault-tolerant core pair. Counts retired instructions and strobes spc to checkpoint the PC every CKPT_INTERVAL commits. On a lockstep mismatch it halts the cores, replays them from the saved PC, and escalates to a sticky FAIL after MAX_RETRY consecutive unsuccessful rollbacks. Sits between the lockstep checker/voter, the cores' halt/restore interface and the spc instance.

Parameters:
PC_WIDTH, 32, width of PC values (matches spc_i/spc_o).
CKPT_INTERVAL, 16, commits per checkpoint; legal range >=1.
MAX_RETRY, 3, rollbacks allowed without an intervening checkpoint; legal range >=1.
HALT_TIMEOUT, 64, cycles to wait for halt_ack_i before declaring FAIL.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
commit_i  in  1  one instruction retired this cycle
pc_i  in  PC_WIDTH  PC of next instruction, valid with commit_i
error_i  in  1  lockstep mismatch detected this cycle
halt_ack_i  in  1  cores quiesced (level)
spc_q_i  in  PC_WIDTH  current spc_o
spc_save_o  out  1  one-cycle strobe to spc signal
spc_pc_o  out  PC_WIDTH  value driven to spc_i
halt_req_o  out  1  request cores to stop (level)
restore_o  out  1  one-cycle strobe: cores load restore_pc_o as PC
restore_pc_o  out  PC_WIDTH  rollback PC
fail_o  out  1  sticky unrecoverable fault
retry_cnt_o  out  $clog2(MAX_RETRY+1)  rollbacks since last checkpoint
state_o  out  3  current FSM state encoding

Behaviour:
- Reset (rst=1 at clk edge): state RUN; all outputs 0; commit, retry and timeout counters 0; save-pending flag clear.
- States: RUN=0, HALT=1, RESTORE=2, RESUME=3, FAIL=4.
- RUN: each commit_i increments the commit counter. On the commit that makes it CKPT_INTERVAL: counter -> 0, pc_i captured into spc_pc_o, save-pending set.
- spc_save_o = save_pending & (state==RUN) & ~error_i (combinational gate; registered pending). A save clears save_pending and retry_cnt.
- Net checkpoint latency: spc_save_o asserts 1 cycle after the Nth commit. spc_o reflects the new value per spc timing.
- error_i in RUN:
  - If retry_cnt==MAX_RETRY: go to FAIL.
  - Otherwise: go to HALT. The commit in the same cycle is ignored and save_pending is dropped, so a possibly corrupt state is never checkpointed.
- HALT: halt_req_o=1 and the timeout counter increments.
  - halt_ack_i=1: go to RESTORE.
  - Timeout counter reaches HALT_TIMEOUT: go to FAIL.
- RESTORE (exactly 1 cycle): restore_o=1, restore_pc_o=spc_q_i (registered, held until the next restore), halt_req_o=1, retry_cnt++, then go to RESUME.
- RESUME: halt_req_o=0. Wait for halt_ack_i=0, then go to RUN with the commit counter cleared.
- FAIL: halt_req_o=1 and fail_o=1. Absorbing until rst.
- error_i is ignored outside RUN. commit_i is ignored outside RUN.
- retry_cnt saturates at MAX_RETRY.
- rst mid-sequence (any state) returns to RUN immediately. restore_o never extends past the reset edge.

Optional Feature:
SPC_CTRL_ERR_LOG_EN.
- Defined: adds output err_pc_o [PC_WIDTH] and err_count_o [16].
  - err_pc_o captures the most recent pc_i seen with commit_i before the accepted error.
  - err_count_o counts accepted errors in RUN, saturating at 16'hFFFF.
  - Both are cleared by rst.
- Undefined: the ports and logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Package spc_ctrl_pkg: state_e enum (RUN..FAIL, 3-bit), default parameter constants, typedef pc_t.
- Sub-module spc_ckpt_timer: commit counter, pc capture, save_pending, spc_save_o gating. Inputs are the enable (state==RUN), error_i and clear.
- FSM and retry/timeout logic live in spc_ctrl.

Test Plan:
- CKPT_INTERVAL=4: rst 2 cycles, then 4 commits with pc_i 0x100..0x10C -> one spc_save_o pulse, 1 cycle after the 4th commit, with spc_pc_o=0x10C; no other pulses.
- error_i on the 4th commit (pc_i=0x10C) -> no spc_save_o. HALT, halt_ack_i after 3 cycles, then a RESTORE pulse with restore_pc_o=prior spc_q_i (0x20). retry_cnt_o=1. Drop halt_ack_i -> RUN.
- MAX_RETRY=2: three errors with no intervening checkpoint -> two rollbacks, then the third error goes straight to FAIL. fail_o=1 and stays 1 under further commits/errors until rst.
- HALT_TIMEOUT=8: error_i with halt_ack_i held 0 -> halt_req_o high 8 cycles, then FAIL.
- Error, rollback, then 4 commits causing a checkpoint -> retry_cnt_o returns to 0. A later error rolls back to the new checkpoint PC.
- rst asserted while in RESTORE -> next cycle state_o=0 and all outputs 0. With SPC_CTRL_ERR_LOG_EN defined, err_count_o also returns to 0.
